// File: rtl/wallace_tree.sv
// ============================================================================
// Module   : wallace_tree
// Brief    : Eight-operand Wallace-tree adder (3:2 CSA reduction + final CPA)
//            with a single registered output stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wallace_tree #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] PP1,
    input  logic [WIDTH-1:0] PP2,
    input  logic [WIDTH-1:0] PP3,
    input  logic [WIDTH-1:0] PP4,
    input  logic [WIDTH-1:0] PP5,
    input  logic [WIDTH-1:0] PP6,
    input  logic [WIDTH-1:0] PP7,
    input  logic [WIDTH-1:0] PP8,
    output logic [WIDTH-1:0] product,
    output logic             out_valid
);

    localparam logic [WIDTH-1:0] c_zero = '0;

    // Returns {carry, sum}; the carry out of the MSB falls off the left shift.
    function automatic logic [2*WIDTH-1:0] csa(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] c
    );
        logic [WIDTH-1:0] maj;
        maj = (a & b) | (a & c) | (b & c);
        return {maj[WIDTH-2:0], 1'b0, a ^ b ^ c};
    endfunction

    logic [WIDTH-1:0] w_l1_s0, w_l1_c0, w_l1_s1, w_l1_c1;
    logic [WIDTH-1:0] w_l2_s0, w_l2_c0, w_l2_s1, w_l2_c1;
    logic [WIDTH-1:0] w_l3_s0, w_l3_c0;
    logic [WIDTH-1:0] w_l4_s0, w_l4_c0;
    logic [WIDTH-1:0] w_sum;

    // 8 -> 6 -> 4 -> 3 -> 2 vectors
    assign {w_l1_c0, w_l1_s0} = csa(PP1, PP2, PP3);
    assign {w_l1_c1, w_l1_s1} = csa(PP4, PP5, PP6);

    assign {w_l2_c0, w_l2_s0} = csa(w_l1_s0, w_l1_c0, w_l1_s1);
    assign {w_l2_c1, w_l2_s1} = csa(w_l1_c1, PP7, PP8);

    assign {w_l3_c0, w_l3_s0} = csa(w_l2_s0, w_l2_c0, w_l2_s1);

    assign {w_l4_c0, w_l4_s0} = csa(w_l3_s0, w_l3_c0, w_l2_c1);

    assign w_sum = w_l4_s0 + w_l4_c0;

    logic [WIDTH-1:0] r_product;
    logic             r_out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_product   <= c_zero;
            r_out_valid <= 1'b0;
        end else begin
            r_product   <= w_sum;
            r_out_valid <= in_valid;
        end
    end

    assign product   = r_product;
    assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_wallace_tree.sv
// ============================================================================
// Module   : tb_wallace_tree
// Brief    : Directed and random self-checking bench for wallace_tree.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wallace_tree;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] pp [8];
    logic [WIDTH-1:0] product;
    logic             out_valid;

    int n_checks;
    int n_fail;

    wallace_tree #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .PP1       (pp[0]),
        .PP2       (pp[1]),
        .PP3       (pp[2]),
        .PP4       (pp[3]),
        .PP5       (pp[4]),
        .PP6       (pp[5]),
        .PP7       (pp[6]),
        .PP8       (pp[7]),
        .product   (product),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [WIDTH-1:0] p0, input logic [WIDTH-1:0] p1,
                         input logic [WIDTH-1:0] p2, input logic [WIDTH-1:0] p3,
                         input logic [WIDTH-1:0] p4, input logic [WIDTH-1:0] p5,
                         input logic [WIDTH-1:0] p6, input logic [WIDTH-1:0] p7,
                         input logic v);
        pp[0] = p0; pp[1] = p1; pp[2] = p2; pp[3] = p3;
        pp[4] = p4; pp[5] = p5; pp[6] = p6; pp[7] = p7;
        in_valid = v;
    endtask

    // Advance one clock edge, then compare the registered outputs.
    task automatic step_check(input string tag, input logic [WIDTH-1:0] exp_p, input logic exp_v);
        @(posedge clk);
        #1;
        check({tag, "_product"}, product, exp_p);
        check({tag, "_valid"}, {{(WIDTH-1){1'b0}}, out_valid}, {{(WIDTH-1){1'b0}}, exp_v});
    endtask

    initial begin
        logic [WIDTH-1:0] ref_sum;
        logic             ref_v;
        n_checks = 0;
        n_fail   = 0;

        // Reset held low while nonzero inputs toggle through several edges
        rst_n = 1'b0;
        drive(32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10, 32'd11, 32'd12, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("reset_product", product, 32'd0);
        check("reset_valid", {31'd0, out_valid}, 32'd0);

        #2 rst_n = 1'b1;

        drive(32'd0, 32'd1, 32'd2, 32'd4, 32'd8, 32'd16, 32'd32, 32'd64, 1'b1);
        step_check("powers", 32'd127, 1'b1);

        drive(32'd0, 32'd1, 32'd3, 32'd7, 32'd15, 32'd31, 32'd63, 32'd127, 1'b1);
        step_check("ramp", 32'd247, 1'b1);

        drive(32'd11111, 32'd22222, 32'd33333, 32'd44444,
              32'd88888, 32'd166666, 32'd322222, 32'd644444, 1'b1);
        step_check("large", 32'd1333330, 1'b1);

        // Async reset between edges clears a nonzero product immediately
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_product", product, 32'd0);
        check("async_reset_valid", {31'd0, out_valid}, 32'd0);
        #1 rst_n = 1'b1;

        drive(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        step_check("all_ones", 32'hFFFFFFF8, 1'b1);

        drive(32'h80000000, 32'h80000000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
        step_check("msb_wrap", 32'd0, 1'b1);

        drive(32'hFFFFFFFB, 32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
        step_check("signed_neg", 32'hFFFFFFFE, 1'b1);

        // Operands change every cycle; product updates even when in_valid is low
        drive(32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 1'b1);
        step_check("pipe_a", 32'd8, 1'b1);
        drive(32'd100, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd200, 1'b0);
        step_check("pipe_b", 32'd300, 1'b0);
        drive(32'hAAAAAAAA, 32'h55555555, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
        step_check("pipe_c", 32'd0, 1'b1);

        // Random sweep against a plain modulo-2^32 sum
        for (int i = 0; i < 10000; i++) begin
            ref_sum = '0;
            for (int k = 0; k < 8; k++) begin
                pp[k]   = $urandom;
                ref_sum = ref_sum + pp[k];
            end
            ref_v    = 1'($urandom_range(0, 1));
            in_valid = ref_v;
            step_check("random", ref_sum, ref_v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wallace_tree.md
Name: wallace_tree

Overview:
Multi-operand adder for the 16-bit signed Booth multiplier datapath.
- Reduces eight 32-bit Booth partial products to one 32-bit sum using a Wallace tree of 3:2 carry-save adders and a final carry-propagate adder.
- The result is registered, giving a single-cycle-latency pipeline stage between partial-product generation and the multiplier output.

Parameters:
- WIDTH, 32, width of every partial product and of the product. All arithmetic is modulo 2^WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  PP1..PP8 hold a valid operand set this cycle
- PP1  input  WIDTH  partial product 1, two's complement, pre-shifted and sign-extended by the producer
- PP2 .. PP8  input  WIDTH each  partial products 2..8, same format as PP1
- product  output  WIDTH  registered sum of PP1..PP8, modulo 2^WIDTH
- out_valid  output  1  product is valid this cycle

Behaviour:
- Reset:
  - rst_n low asynchronously forces product = 0 and out_valid = 0, regardless of clk.
  - Reset asserted mid-operation discards any in-flight result.
  - After rst_n deasserts, the first capture is at the next rising clk edge.
- Function: product = (PP1+PP2+PP3+PP4+PP5+PP6+PP7+PP8) mod 2^WIDTH.
  - Signed and unsigned interpretations give identical bits.
  - Overflow wraps silently; there is no overflow flag.
- Reduction structure (combinational, all vectors WIDTH bits):
  - Each 3:2 CSA produces sum = a^b^c and carry = majority(a,b,c) shifted left by 1; the carry-out of the MSB is dropped.
  - L1: CSA(PP1,PP2,PP3), CSA(PP4,PP5,PP6); PP7 and PP8 pass through. 8 -> 6 vectors.
  - L2: two CSAs over the 6 vectors. 6 -> 4.
  - L3: one CSA plus one pass-through. 4 -> 3.
  - L4: one CSA. 3 -> 2.
  - Final: ripple or any CPA, carry-in 0, carry-out discarded.
  - Behavioural '+' over all eight inputs is not acceptable. The CSA tree must be explicit; the final CPA may use '+'.
- Timing:
  - On each rising clk edge with rst_n high, the registers capture: product <= tree result of current inputs; out_valid <= in_valid.
  - Latency is exactly 1 cycle; throughput is one operand set per cycle.
- Gating:
  - product updates every cycle regardless of in_valid (no hold).
  - Consumers qualify product with out_valid.
- No internal state other than the two registered outputs; no stall or backpressure.
- X-free: known inputs must produce a known product.

Test Plan:
- Reset: hold rst_n=0, drive nonzero inputs and toggle clk -> product=0, out_valid=0. Assert rst_n low asynchronously between edges while product is nonzero -> product clears immediately.
- Powers: PP1..PP8 = 0,1,2,4,8,16,32,64 with in_valid=1 -> one cycle later product=127, out_valid=1.
- Ramp: PP1..PP8 = 0,1,3,7,15,31,63,127 -> product=247.
- Large: PP1..PP8 = 11111,22222,33333,44444,88888,166666,322222,644444 -> product=1333330.
- Signed/wrap:
  - All eight = 0xFFFFFFFF -> product=0xFFFFFFF8 (-8).
  - PP1=PP2=0x80000000, rest 0 -> product=0.
  - PP1=-5, PP2=3, rest 0 -> product=0xFFFFFFFE.
- Pipeline: change operands every cycle with in_valid toggling 1,0,1 -> product tracks each set one cycle later and out_valid follows in_valid delayed by one cycle. A 10k-vector random sweep matches a modulo-2^32 reference sum.
